// File: rtl/spi_slave_tx_pkg.sv
// Shared types for the SPI transmit responder: frame FSM states and the miso idle level.
package spi_slave_tx_pkg;

  typedef enum logic [1:0] {
    IDLE         = 2'd0,
    SHIFT        = 2'd1,
    WAIT_SS_HIGH = 2'd2
  } state_e;

  localparam logic MISO_IDLE = 1'b0;

endpackage

// File: rtl/spi_slave_tx_if.sv
// Load handshake, SPI pins and status pulses of the SPI transmit responder.
interface spi_slave_tx_if #(
  parameter int bits = 16
);

  logic [bits-1:0] tx_data;
  logic            tx_valid;
  logic            tx_ready;
  logic            ss;
  logic            sclk;
  logic            miso;
  logic            busy;
  logic            done;
  logic            underrun;

  modport slave (
    input  tx_data, tx_valid, ss, sclk,
    output tx_ready, miso, busy, done, underrun
  );

  modport master (
    output tx_data, tx_valid, ss, sclk,
    input  tx_ready, miso, busy, done, underrun
  );

endinterface

// File: rtl/spi_slave_tx_sync_edge.sv
// 2-FF synchroniser with a previous-value flop; rise/fall pulses come from the synchronised value.
module spi_slave_tx_sync_edge (
  input  logic clk,
  input  logic rst,
  input  logic d_i,
  output logic rise_o,
  output logic fall_o
);

  logic meta_q;
  logic sync_q;
  logic prev_q;

  // All flops reset to 0 so a line already low at reset release yields no fall.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
      prev_q <= 1'b0;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
      prev_q <= sync_q;
    end
  end

  assign rise_o = sync_q & ~prev_q;
  assign fall_o = ~sync_q & prev_q;

endmodule

// File: rtl/spi_slave_tx.sv
// Mode-0 SPI transmit-only responder: double-buffered word, MSB first on miso while ss is low.
// Pin-to-response latency is three clk edges (two sync stages plus the registered output).
module spi_slave_tx
  import spi_slave_tx_pkg::*;
#(
  parameter int bits = 16
) (
  input logic            clk,
  input logic            rst,
  spi_slave_tx_if.slave  bus
);

  localparam int CW = $clog2(bits + 1);

  logic ss_rise, ss_fall, sclk_rise, sclk_fall;

  spi_slave_tx_sync_edge u_ss_sync (
    .clk    (clk),
    .rst    (rst),
    .d_i    (bus.ss),
    .rise_o (ss_rise),
    .fall_o (ss_fall)
  );

  spi_slave_tx_sync_edge u_sclk_sync (
    .clk    (clk),
    .rst    (rst),
    .d_i    (bus.sclk),
    .rise_o (sclk_rise),
    .fall_o (sclk_fall)
  );

  state_e          state_q, state_d;
  logic [bits-1:0] shift_q, shift_d;
  logic [bits-1:0] hold_q, hold_d;
  logic            hold_full_q, hold_full_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            miso_q, miso_d;
  logic            done_q, done_d;
  logic            underrun_q, underrun_d;
  logic            accept;

  assign accept = bus.tx_valid && !hold_full_q;

  always_comb begin
    state_d     = state_q;
    shift_d     = shift_q;
    cnt_d       = cnt_q;
    done_d      = 1'b0;
    underrun_d  = 1'b0;
    hold_d      = accept ? bus.tx_data : hold_q;
    hold_full_d = hold_full_q | accept;

    unique case (state_q)
      IDLE: begin
        // The frame sees the holding register as it was before any same-cycle accept.
        if (ss_fall) begin
          if (hold_full_q) begin
            shift_d     = hold_q;
            hold_full_d = 1'b0;
          end else begin
            shift_d    = '0;
            underrun_d = 1'b1;
          end
          cnt_d   = '0;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        if (ss_rise) begin
          state_d = IDLE;
        end else if (sclk_rise) begin
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == CW'(bits - 1)) begin
            done_d  = 1'b1;
            state_d = WAIT_SS_HIGH;
          end
        end else if (sclk_fall) begin
          shift_d = {shift_q[bits-2:0], 1'b0};
        end
      end
      WAIT_SS_HIGH: begin
        if (ss_rise) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    miso_d = (state_d == SHIFT) ? shift_d[bits-1] : MISO_IDLE;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      shift_q     <= '0;
      hold_q      <= '0;
      hold_full_q <= 1'b0;
      cnt_q       <= '0;
      miso_q      <= MISO_IDLE;
      done_q      <= 1'b0;
      underrun_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      shift_q     <= shift_d;
      hold_q      <= hold_d;
      hold_full_q <= hold_full_d;
      cnt_q       <= cnt_d;
      miso_q      <= miso_d;
      done_q      <= done_d;
      underrun_q  <= underrun_d;
    end
  end

  assign bus.tx_ready = !hold_full_q;
  assign bus.miso     = miso_q;
  assign bus.busy     = (state_q == SHIFT);
  assign bus.done     = done_q;
  assign bus.underrun = underrun_q;

endmodule

// File: tb/tb_spi_slave_tx.sv
// Directed bench for spi_slave_tx: the bench acts as SPI master, expected words go into a
// scoreboard queue and are compared against the sampled bits whenever done pulses.
module tb_spi_slave_tx;

  localparam int BITS = 16;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  spi_slave_tx_if #(.bits(BITS)) bus ();

  spi_slave_tx #(.bits(BITS)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  int          last_rise_cyc = 0;
  int          done_cnt = 0;
  int          underrun_cnt = 0;
  logic [15:0] rx_word = '0;
  logic [15:0] exp_q[$];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: every done pulse retires one expected frame from the scoreboard.
  always @(negedge clk) begin
    logic [15:0] exp_word;
    if (rst && bus.underrun) underrun_cnt++;
    if (rst && bus.done) begin
      done_cnt++;
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done: got done with empty scoreboard at cycle %0d", cyc);
      end else begin
        exp_word = exp_q.pop_front();
        chk("frame_data", rx_word, exp_word);
        chk("done_latency", cyc - last_rise_cyc, 3);
      end
    end
  end

  task automatic clks(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic load(input logic [15:0] w);
    int t;
    t = 0;
    bus.tx_data  = w;
    bus.tx_valid = 1'b1;
    while (!bus.tx_ready && t < 200) begin
      clks(1);
      t++;
    end
    if (!bus.tx_ready) begin
      checks++;
      errors++;
      $display("FAIL load_timeout: tx_ready stayed 0 for %0d cycles, required 1", t);
    end
    clks(1);
    bus.tx_valid = 1'b0;
  endtask

  task automatic sclk_pulse();
    bus.sclk = 1'b1;
    clks(5);
    bus.sclk = 1'b0;
    clks(5);
  endtask

  task automatic frame(input int npulses, input logic [15:0] exp, input bit expect_done);
    rx_word = '0;
    if (expect_done) exp_q.push_back(exp);
    bus.ss = 1'b0;
    clks(6);
    chk("busy_in_frame", bus.busy, 1);
    chk("ready_in_frame", bus.tx_ready, 1);
    for (int i = 0; i < npulses; i++) begin
      bus.sclk = 1'b1;
      if (i < BITS) rx_word = {rx_word[14:0], bus.miso};
      else chk("miso_extra_clk", bus.miso, 0);
      if (i == BITS - 1) last_rise_cyc = cyc;
      clks(5);
      bus.sclk = 1'b0;
      clks(5);
    end
    bus.ss = 1'b1;
    clks(3);
    chk("busy_after_ss_high", bus.busy, 0);
    chk("miso_after_ss_high", bus.miso, 0);
    clks(3);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1);
  end

  initial begin
    bus.ss       = 1'b1;
    bus.sclk     = 1'b0;
    bus.tx_valid = 1'b0;
    bus.tx_data  = '0;
    rst          = 1'b0;
    clks(3);
    chk("rst_miso", bus.miso, 0);
    chk("rst_ready", bus.tx_ready, 1);
    chk("rst_busy", bus.busy, 0);
    chk("rst_done", bus.done, 0);
    chk("rst_underrun", bus.underrun, 0);
    rst = 1'b1;
    clks(5);

    // Normal frame
    load(16'hA5C3);
    chk("ready_after_load", bus.tx_ready, 0);
    frame(16, 16'hA5C3, 1'b1);
    chk("done_cnt_normal", done_cnt, 1);
    chk("underrun_cnt_normal", underrun_cnt, 0);

    // Underrun
    frame(16, 16'h0000, 1'b1);
    chk("underrun_cnt_empty", underrun_cnt, 1);
    chk("done_cnt_empty", done_cnt, 2);

    // Double buffering
    load(16'h1234);
    fork
      frame(16, 16'h1234, 1'b1);
      begin
        clks(40);
        load(16'hBEEF);
        chk("ready_after_midframe_load", bus.tx_ready, 0);
      end
    join
    chk("ready_held_between_frames", bus.tx_ready, 0);
    frame(16, 16'hBEEF, 1'b1);
    chk("done_cnt_dbuf", done_cnt, 4);
    chk("underrun_cnt_dbuf", underrun_cnt, 1);

    // Abort after 5 pulses, then the next frame underruns
    load(16'h00FF);
    frame(5, 16'h0000, 1'b0);
    chk("done_cnt_abort", done_cnt, 4);
    frame(16, 16'h0000, 1'b1);
    chk("underrun_cnt_after_abort", underrun_cnt, 2);
    chk("done_cnt_after_abort", done_cnt, 5);

    // Extra sclk pulses
    load(16'h3C96);
    frame(20, 16'h3C96, 1'b1);
    chk("done_cnt_extra", done_cnt, 6);

    // Reset mid-frame with ss held low
    load(16'h5555);
    bus.ss = 1'b0;
    clks(6);
    repeat (4) sclk_pulse();
    chk("busy_before_reset", bus.busy, 1);
    rst = 1'b0;
    clks(2);
    chk("midrst_miso", bus.miso, 0);
    chk("midrst_ready", bus.tx_ready, 1);
    chk("midrst_busy", bus.busy, 0);
    rst = 1'b1;
    clks(3);
    repeat (16) sclk_pulse();
    chk("busy_ignored_after_reset", bus.busy, 0);
    chk("done_cnt_ignored", done_cnt, 6);
    chk("underrun_cnt_ignored", underrun_cnt, 2);
    bus.ss = 1'b1;
    clks(6);
    load(16'h8001);
    frame(16, 16'h8001, 1'b1);
    chk("done_cnt_final", done_cnt, 7);
    chk("scoreboard_empty", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/spi_slave_tx.md
# spi_slave_tx

Transmit-only SPI responder for the voltmeter design: the far end of the existing SPI master's `ss`/`sclk`/`miso` link. It serialises parameter-width words, MSB first, onto `miso` while selected. It is used as a synthesizable ADC emulator for loopback bring-up and for closed-loop verification of the master. It oversamples `ss` and `sclk` in the system clock domain and double-buffers the transmit word, with a valid/ready load handshake.

## Interface

- `bits`, 16, frame length in sclk cycles and word width (≥2)
- `clk`  in  1  system clock
- `rst`  in  1  asynchronous, active-low reset
- `tx_data`  in  bits  word to transmit next
- `tx_valid`  in  1  `tx_data` offered
- `tx_ready`  out  1  holding register empty; word accepted when `tx_valid && tx_ready`
- `ss`  in  1  slave select from master, active-low
- `sclk`  in  1  serial clock from master, idle low
- `miso`  out  1  serial data, registered; 0 when not shifting
- `busy`  out  1  frame in progress (SHIFT state)
- `done`  out  1  one-cycle pulse: full frame transmitted
- `underrun`  out  1  one-cycle pulse: frame started with empty holding register

## Operation

- **Mode.** SPI mode 0. The master samples `miso` on the rising edge of `sclk`. The slave updates `miso` on the falling edge of `sclk`.
- **Synchronisers.** `ss` and `sclk` each pass through a 2-FF synchroniser with a previous-value register.
  - Edges are detected on the synchronised value.
  - All synchroniser flops reset to 0. An `ss` already low at reset release therefore produces no falling edge.
- **Holding register.**
  - `tx_ready = !hold_full`.
  - An accept sets `hold_full`.
  - Loads are accepted in any state, including during SHIFT (double buffering).
- **States:** IDLE, SHIFT, WAIT_SS_HIGH.
  - **IDLE**, on `ss` falling edge:
    - If `hold_full`: shift register ← hold, clear `hold_full`.
    - Else: shift register ← 0 and pulse `underrun`.
    - Bit counter ← 0; go to SHIFT.
  - **SHIFT**
    - `miso` = shift register MSB.
    - On `sclk` rising edge: counter++. When counter reaches `bits`, pulse `done` and go to WAIT_SS_HIGH.
    - On `sclk` falling edge: shift left by 1, filling 0.
    - On `ss` rising edge: abort and go to IDLE. No `done`; the word is discarded.
  - **WAIT_SS_HIGH**
    - `miso` = 0; all `sclk` edges are ignored.
    - On `ss` rising edge: go to IDLE.
- **Simultaneous events.**
  - An accept in the same cycle as an `ss` falling edge with the holding register empty: the frame sees empty, so `underrun` pulses and the frame sends zeros. The new word stays held for the next frame.
  - `ss` rising and `sclk` edge in the same cycle: the `ss` edge wins.
- **Reset.** Asserting `rst` mid-frame clears all state immediately. The next frame needs `ss` to be seen high, then low.

## Timing

- **Reset values:**
  - `miso` = 0
  - `tx_ready` = 1
  - `busy` = 0
  - `done` = 0
  - `underrun` = 0
  - state = IDLE
  - `hold_full` = 0
- **Latency.** Three `clk` rising edges from a pin transition of `ss` or `sclk` to the registered response:
  - first `miso` bit, `busy` and `underrun` after `ss` falls;
  - next `miso` bit after `sclk` falls;
  - `done` after the `bits`-th `sclk` rises.
- `tx_ready` rises in the cycle after a frame loads from the holding register.
- **Constraint on the master.** `sclk` high and low phases must each be ≥4 `clk` periods. `ss` must fall ≥4 `clk` before the first `sclk` rise.
- **Data hold.** The last bit stays valid on `miso` until the `bits`-th rising edge is detected.

## Structure

- **`spi_pkg`:** state enum typedef (IDLE, SHIFT, WAIT_SS_HIGH) and the `miso` idle-level constant.
- **`sync_edge` sub-module:** 2-FF synchroniser plus rise/fall pulse outputs, with asynchronous active-low reset to 0. It is instantiated twice, once for `ss` and once for `sclk`.
- Counter width is `$clog2(bits+1)`.

## Test plan

1. **Normal frame.** Reset, load `0xA5C3`, then one 16-bit frame with `sclk` = `clk`/10.
   - Bits sampled on `sclk` rises read `0xA5C3`, MSB first.
   - `done` pulses once, 3 clk after the 16th rise.
   - `tx_ready` returns to 1 after the frame loads.
2. **Underrun.** Frame with no word loaded → `underrun` pulses once, `miso` stays 0, and `done` still pulses.
3. **Double buffering.** Load `0x1234`, start a frame, load `0xBEEF` mid-frame.
   - `tx_ready` = 0 from the second load until the second frame starts.
   - Frames read `0x1234`, then `0xBEEF`.
4. **Abort.** Load `0x00FF`, raise `ss` after 5 `sclk` pulses.
   - No `done`; `busy` = 0 and `miso` = 0 within 3 clk.
   - The next frame reads the next loaded word (or underruns if none is loaded).
5. **Extra clocks.** Send 20 `sclk` pulses in a 16-bit frame → `done` pulses once; `miso` = 0 and the shift state is unchanged for pulses 17–20.
6. **Reset mid-frame.** Assert `rst` mid-frame with `ss` held low.
   - All outputs take their reset values.
   - Further `sclk` pulses are ignored until `ss` goes high then low.
   - The following frame with `0x8001` loaded reads correctly.
